tag_alloc: RTL and testbench

TAG_ALLOC -- requirements
Module: tag_alloc

---
 rtl/tag_alloc_pkg.sv | 10 +
 rtl/tag_alloc_rr_ffz.sv | 30 +++
 rtl/tag_alloc.sv | 111 +++++++++++
 tb/tb_tag_alloc.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tag_alloc_pkg.sv
// rtl/tag_alloc_pkg.sv - shared types for the tag allocator
package tag_alloc_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/tag_alloc_rr_ffz.sv
// rtl/tag_alloc_rr_ffz.sv - circular first-zero search starting at a given index
module rr_ffz #(
    parameter int W = 16,
    localparam int ENC_W = $clog2(W)
) (
    input  logic [W-1:0]     vec,
    input  logic [ENC_W-1:0] start,
    output logic [W-1:0]     onehot,
    output logic [ENC_W-1:0] enc,
    output logic             any
);

    // Walk W positions from start; W is a power of two so the index wraps for free.
    always_comb begin
        logic [ENC_W-1:0] idx;
        onehot = '0;
        enc    = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = 0; i < W; i++) begin
            idx = start + ENC_W'(i);
            if (!any && !vec[idx]) begin
                any         = 1'b1;
                enc         = idx;
                onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tag_alloc.sv
// rtl/tag_alloc.sv - round-robin tag allocator with release, flush and busy tracking
module tag_alloc
    import tag_alloc_pkg::*;
#(
    parameter int W = 16,
    localparam int ENC_W = $clog2(W)
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_flush,
    output logic             o_alloc_vld,
    input  logic             i_alloc_rdy,
    output logic [ENC_W-1:0] o_alloc_tag,
    input  logic             i_free_vld,
    input  logic [ENC_W-1:0] i_free_tag,
    output logic [W-1:0]     o_busy,
    output logic [ENC_W:0]   o_cnt,
    output logic             o_full,
    output logic             o_err
);

    localparam logic [ENC_W-1:0] ENC_ONE  = ENC_W'(1);
    localparam logic [ENC_W:0]   CNT_FULL = (ENC_W+1)'(W);
    localparam logic [W-1:0]     OH_ZERO  = W'(1);

    state_t           state, state_nxt;
    logic [W-1:0]     busy, busy_nxt;
    logic [ENC_W-1:0] ptr, ptr_nxt;
    logic [W-1:0]     offer_oh, cand_oh_nxt;
    logic [ENC_W-1:0] cand_tag_nxt;
    logic             cand_vld, cand_vld_nxt;
    logic [ENC_W:0]   cnt, cnt_nxt;
    logic             full, full_nxt;
    logic             err, err_nxt;
    logic             flush_go, clear_all, hs, rel_req, rel_hit;
    logic [W-1:0]     hs_oh, rel_oh;

    assign o_alloc_vld = (state == RUN) && cand_vld && !full;
    assign o_busy      = busy;
    assign o_cnt       = cnt;
    assign o_full      = full;
    assign o_err       = err;

    // Flush in RUN wins over any same-cycle handshake or release.
    assign flush_go  = (state == RUN) && i_flush;
    assign clear_all = flush_go || (state == FLUSH);
    assign hs        = o_alloc_vld && i_alloc_rdy && !flush_go;
    assign rel_req   = i_free_vld && (state != FLUSH) && !flush_go;
    assign rel_hit   = rel_req && busy[i_free_tag];
    assign hs_oh     = hs ? offer_oh : '0;
    assign rel_oh    = rel_hit ? (OH_ZERO << i_free_tag) : '0;

    // Next-state logic of the INIT/RUN/FLUSH sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    state_nxt = RUN;
            RUN:     if (i_flush) state_nxt = FLUSH;
            FLUSH:   state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    // Next busy vector, pointer, count and sticky error.
    always_comb begin
        busy_nxt = (busy | hs_oh) & ~rel_oh;
        ptr_nxt  = hs ? (o_alloc_tag + ENC_ONE) : ptr;
        cnt_nxt  = cnt + {{ENC_W{1'b0}}, hs} - {{ENC_W{1'b0}}, rel_hit};
        err_nxt  = err | (rel_req && !busy[i_free_tag]);
        if (clear_all) begin
            busy_nxt = '0;
            ptr_nxt  = '0;
            cnt_nxt  = '0;
        end
        full_nxt = (cnt_nxt == CNT_FULL);
    end

    rr_ffz #(.W(W)) u_ffz (
        .vec    (busy_nxt),
        .start  (ptr_nxt),
        .onehot (cand_oh_nxt),
        .enc    (cand_tag_nxt),
        .any    (cand_vld_nxt)
    );

    // State and registered outputs; reset drops every allocation at once.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state       <= INIT;
            busy        <= '0;
            ptr         <= '0;
            o_alloc_tag <= '0;
            offer_oh    <= OH_ZERO;
            cand_vld    <= 1'b1;
            cnt         <= '0;
            full        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            busy        <= busy_nxt;
            ptr         <= ptr_nxt;
            o_alloc_tag <= cand_tag_nxt;
            offer_oh    <= cand_oh_nxt;
            cand_vld    <= cand_vld_nxt;
            cnt         <= cnt_nxt;
            full        <= full_nxt;
            err         <= err_nxt;
        end
    end

endmodule

// File: tb/tb_tag_alloc.sv
// tb/tb_tag_alloc.sv - directed table plus randomized model check of tag_alloc
module tb_tag_alloc;

    localparam int W = 4;
    localparam int ENC_W = $clog2(W);

    logic             i_clk = 1'b0;
    logic             i_arst_n = 1'b0;
    logic             i_flush = 1'b0;
    logic             o_alloc_vld;
    logic             i_alloc_rdy = 1'b0;
    logic [ENC_W-1:0] o_alloc_tag;
    logic             i_free_vld = 1'b0;
    logic [ENC_W-1:0] i_free_tag = '0;
    logic [W-1:0]     o_busy;
    logic [ENC_W:0]   o_cnt;
    logic             o_full;
    logic             o_err;

    int checks = 0;
    int errors = 0;

    tag_alloc #(.W(W)) dut (
        .i_clk       (i_clk),
        .i_arst_n    (i_arst_n),
        .i_flush     (i_flush),
        .o_alloc_vld (o_alloc_vld),
        .i_alloc_rdy (i_alloc_rdy),
        .o_alloc_tag (o_alloc_tag),
        .i_free_vld  (i_free_vld),
        .i_free_tag  (i_free_tag),
        .o_busy      (o_busy),
        .o_cnt       (o_cnt),
        .o_full      (o_full),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       flush, rdy, fvld;
        logic [1:0] ftag;
        logic       e_vld;
        logic [1:0] e_tag;
        logic [3:0] e_busy;
        logic [2:0] e_cnt;
        logic       e_full, e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic fl, rd, fv, input logic [1:0] ft,
                                input logic ev, input logic [1:0] et, input logic [3:0] eb,
                                input logic [2:0] ec, input logic ef, ee);
        vec_t v;
        v.flush = fl; v.rdy = rd; v.fvld = fv; v.ftag = ft;
        v.e_vld = ev; v.e_tag = et; v.e_busy = eb; v.e_cnt = ec; v.e_full = ef; v.e_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: a set of busy tags, a scan pointer and a phase.
    bit m_busy[W];
    int m_ptr;
    int m_phase;   // 0 = just out of reset, 1 = running, 2 = flushing
    bit m_err;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < W; i++) c += m_busy[i];
        return c;
    endfunction

    function automatic int m_cand();
        for (int i = 0; i < W; i++)
            if (!m_busy[(m_ptr + i) % W]) return (m_ptr + i) % W;
        return -1;
    endfunction

    function automatic int m_busy_vec();
        int v = 0;
        for (int i = 0; i < W; i++) if (m_busy[i]) v += (1 << i);
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < W; i++) m_busy[i] = 1'b0;
        m_ptr = 0; m_phase = 0; m_err = 1'b0;
    endtask

    task automatic m_step(input bit fl, input bit rd, input bit fv, input int ft);
        bit offer;
        bit was_busy;
        int t;
        offer = (m_phase == 1) && (m_count() < W);
        t = m_cand();
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 2 || fl) begin
            for (int i = 0; i < W; i++) m_busy[i] = 1'b0;
            m_ptr = 0;
            m_phase = (m_phase == 2) ? 1 : 2;
        end else begin
            was_busy = m_busy[ft];
            if (offer && rd) begin
                m_busy[t] = 1'b1;
                m_ptr = (t + 1) % W;
            end
            if (fv) begin
                if (was_busy) m_busy[ft] = 1'b0;
                else m_err = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        i_flush = 0; i_alloc_rdy = 0; i_free_vld = 0; i_free_tag = 0;
        i_arst_n = 0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_arst_n = 1;
        m_reset();
        #1;
    endtask

    initial begin
        bit fl, rd, fv;
        int ft, vld_exp;

        tbl.push_back(mk(0,1,0,0, 1,0,4'b0000,0,0,0));
        tbl.push_back(mk(0,1,0,0, 1,1,4'b0001,1,0,0));
        tbl.push_back(mk(0,1,0,0, 1,2,4'b0011,2,0,0));
        tbl.push_back(mk(0,1,0,0, 1,3,4'b0111,3,0,0));
        tbl.push_back(mk(0,1,0,0, 0,0,4'b1111,4,1,0));
        tbl.push_back(mk(0,1,0,0, 0,0,4'b1111,4,1,0));
        tbl.push_back(mk(0,1,1,2, 1,2,4'b1011,3,0,0));
        tbl.push_back(mk(0,1,0,0, 0,0,4'b1111,4,1,0));
        tbl.push_back(mk(0,0,1,1, 1,1,4'b1101,3,0,0));
        tbl.push_back(mk(0,0,1,2, 1,1,4'b1001,2,0,0));
        tbl.push_back(mk(0,1,1,0, 1,2,4'b1010,2,0,0));
        tbl.push_back(mk(0,0,1,3, 1,2,4'b0010,1,0,0));
        tbl.push_back(mk(0,0,1,3, 1,2,4'b0010,1,0,1));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0,0,0,0, 1,2,4'b0010,1,0,1));
        tbl.push_back(mk(0,1,0,0, 1,3,4'b0110,2,0,1));
        tbl.push_back(mk(0,1,0,0, 1,0,4'b1110,3,0,1));
        tbl.push_back(mk(1,1,1,1, 0,0,4'b0000,0,0,1));
        tbl.push_back(mk(1,1,1,1, 1,0,4'b0000,0,0,1));
        tbl.push_back(mk(0,1,0,0, 1,1,4'b0001,1,0,1));

        do_reset();
        check("rst_vld",  o_alloc_vld, 0);
        check("rst_busy", o_busy, 0);
        check("rst_cnt",  o_cnt, 0);
        check("rst_full", o_full, 0);
        check("rst_err",  o_err, 0);
        check("rst_tag",  o_alloc_tag, 0);

        foreach (tbl[k]) begin
            i_flush = tbl[k].flush; i_alloc_rdy = tbl[k].rdy;
            i_free_vld = tbl[k].fvld; i_free_tag = tbl[k].ftag;
            @(posedge i_clk);
            #1;
            check($sformatf("row%0d_vld", k), o_alloc_vld, tbl[k].e_vld);
            if (tbl[k].e_vld) check($sformatf("row%0d_tag", k), o_alloc_tag, tbl[k].e_tag);
            check($sformatf("row%0d_busy", k), o_busy, tbl[k].e_busy);
            check($sformatf("row%0d_cnt", k), o_cnt, tbl[k].e_cnt);
            check($sformatf("row%0d_full", k), o_full, tbl[k].e_full);
            check($sformatf("row%0d_err", k), o_err, tbl[k].e_err);
        end
        i_flush = 0; i_alloc_rdy = 0; i_free_vld = 0;

        // Reset mid-operation must clear allocations without a clock edge.
        i_arst_n = 0;
        #1;
        check("arst_busy", o_busy, 0);
        check("arst_cnt",  o_cnt, 0);
        check("arst_vld",  o_alloc_vld, 0);
        check("arst_err",  o_err, 0);

        for (int chunk = 0; chunk < 4; chunk++) begin
            do_reset();
            for (int n = 0; n < 500; n++) begin
                fl = ($urandom_range(0, 15) == 0);
                rd = $urandom_range(0, 1);
                fv = (m_phase != 0) && ($urandom_range(0, 1) == 1);
                ft = $urandom_range(0, W - 1);
                if (chunk < 2 && fv) begin
                    // Mostly release tags that are actually busy so the set churns.
                    for (int i = 0; i < W; i++)
                        if (m_busy[(ft + i) % W]) begin ft = (ft + i) % W; break; end
                end
                i_flush = fl; i_alloc_rdy = rd; i_free_vld = fv; i_free_tag = ft[ENC_W-1:0];
                @(posedge i_clk);
                #1;
                m_step(fl, rd, fv, ft);
                vld_exp = (m_phase == 1) && (m_count() < W);
                check("rnd_vld", o_alloc_vld, vld_exp);
                if (vld_exp != 0) check("rnd_tag", o_alloc_tag, m_cand());
                check("rnd_busy", o_busy, m_busy_vec());
                check("rnd_cnt", o_cnt, m_count());
                check("rnd_full", o_full, int'(m_count() == W));
                check("rnd_err", o_err, m_err);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
